// File: rtl/im2col_reader_pkg.sv
// Shared widths, FSM encoding and FIFO payload for the im2col reader.
package im2col_reader_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_SIZE  = 12;
    localparam int unsigned DIM_W      = 8;
    localparam int unsigned K_W        = 4;

    // Tap coordinate width: holds oy*S+ky+K+S without overflow; negatives wrap high.
    localparam int unsigned COORD_W    = DIM_W + K_W + 4;
    // Full-precision linear CHW address before truncation to ADDR_SIZE.
    localparam int unsigned LIN_W      = 3 * DIM_W + 2;

    // One-hot, matching the ifmap buffer FSM encoding.
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_CHECK  = 5'b00010,
        S_ISSUE  = 5'b00100,
        S_DRAIN  = 5'b01000,
        S_FINISH = 5'b10000
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  col_last;
        logic                  frame_last;
    } col_beat_t;

endpackage

// File: rtl/im2col_reader_fifo2.sv
// Two-entry synchronous FIFO for im2col beats, with flush and occupancy count.
module im2col_reader_fifo2
    import im2col_reader_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      flush_i,
    input  logic      push_i,
    input  col_beat_t push_beat_i,
    input  logic      pop_i,
    output col_beat_t head_o,
    output logic [1:0] count_o
);

    col_beat_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       pop_ok;
    logic       push_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    // Storage, pointers and count; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_beat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/im2col_reader.sv
// Walks oy/ox/c/ky/kx over a CHW ifmap, reads real taps from the buffer,
// inserts zero pad taps without a read, and streams the im2col columns out.
module im2col_reader
    import im2col_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  conv_en,
    input  logic [DIM_W-1:0]      cfg_h,
    input  logic [DIM_W-1:0]      cfg_w,
    input  logic [DIM_W-1:0]      cfg_c,
    input  logic [K_W-1:0]        cfg_k,
    input  logic [K_W-1:0]        cfg_stride,
    input  logic [K_W-1:0]        cfg_pad,
    output logic [ADDR_SIZE-1:0]  tensor_addr,
    output logic                  t_addr_vld,
    input  logic [DATA_WIDTH-1:0] tensor_data,
    output logic [DATA_WIDTH-1:0] col_data,
    output logic                  col_valid,
    input  logic                  col_ready,
    output logic                  col_last,
    output logic                  frame_last,
    output logic                  done
);

    state_e state_q, state_d;

    logic [DIM_W-1:0] h_q, w_q, c_q;
    logic [K_W-1:0]   k_q, s_q, p_q;

    logic [DIM_W-1:0] oy_q, oy_d, ox_q, ox_d, ch_q, ch_d;
    logic [K_W-1:0]   ky_q, ky_d, kx_q, kx_d;

    logic s1_vld_q, s1_pad_q, s1_plast_q, s1_flast_q;

    logic [1:0] fifo_count;
    col_beat_t  fifo_head;
    col_beat_t  push_beat;

    logic [COORD_W-1:0] h_pad, w_pad, iy, ix;
    logic [LIN_W-1:0]   lin_addr;
    logic [2:0]         occ;
    logic pad_tap, illegal, pop, issue;
    logic last_kx, last_ky, last_c, last_ox, last_oy, patch_last, frame_last_tap;

    assign h_pad = COORD_W'(h_q) + COORD_W'({p_q, 1'b0});
    assign w_pad = COORD_W'(w_q) + COORD_W'({p_q, 1'b0});
    assign iy    = COORD_W'(oy_q) * COORD_W'(s_q) + COORD_W'(ky_q) - COORD_W'(p_q);
    assign ix    = COORD_W'(ox_q) * COORD_W'(s_q) + COORD_W'(kx_q) - COORD_W'(p_q);

    // Negative coordinates wrap to large unsigned values, so one compare covers both edges.
    assign pad_tap = (iy >= COORD_W'(h_q)) || (ix >= COORD_W'(w_q));

    assign lin_addr = (LIN_W'(ch_q) * LIN_W'(h_q) + LIN_W'(iy[DIM_W-1:0])) * LIN_W'(w_q)
                    + LIN_W'(ix[DIM_W-1:0]);

    assign illegal = (h_q == '0) || (w_q == '0) || (c_q == '0) || (k_q == '0) || (s_q == '0)
                  || (COORD_W'(k_q) > h_pad) || (COORD_W'(k_q) > w_pad);

    // An output position is the last one when the next window would run past the padded edge.
    assign last_kx = (kx_q == k_q - K_W'(1));
    assign last_ky = (ky_q == k_q - K_W'(1));
    assign last_c  = (ch_q == c_q - DIM_W'(1));
    assign last_ox = (COORD_W'(ox_q) * COORD_W'(s_q) + COORD_W'(s_q) + COORD_W'(k_q)) > w_pad;
    assign last_oy = (COORD_W'(oy_q) * COORD_W'(s_q) + COORD_W'(s_q) + COORD_W'(k_q)) > h_pad;
    assign patch_last     = last_c && last_ky && last_kx;
    assign frame_last_tap = patch_last && last_ox && last_oy;

    // Read strobe is a same-cycle decision so this cycle's pop can free a credit.
    assign col_valid = (fifo_count != 2'd0);
    assign pop       = col_valid && col_ready;
    assign occ       = 3'(fifo_count) + 3'(s1_vld_q) - 3'(pop);
    assign issue     = (state_q == S_ISSUE) && enable && !conv_en && (occ < 3'd2);

    assign t_addr_vld  = issue && !pad_tap;
    assign tensor_addr = t_addr_vld ? ADDR_SIZE'(lin_addr) : '0;
    assign col_data    = col_valid ? fifo_head.data : '0;
    assign col_last    = col_valid && fifo_head.col_last;
    assign frame_last  = col_valid && fifo_head.frame_last;
    assign done        = (state_q == S_FINISH);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state; conv_en restarts from any state.
    always_comb begin
        state_d = state_q;
        if (conv_en) begin
            state_d = S_CHECK;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_CHECK:  state_d = illegal ? S_FINISH : S_ISSUE;
                S_ISSUE:  if (issue && frame_last_tap) state_d = S_DRAIN;
                S_DRAIN:  if (!s1_vld_q && (fifo_count == 2'd0)) state_d = S_FINISH;
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Configuration is captured only on the start pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_q <= '0; w_q <= '0; c_q <= '0;
            k_q <= '0; s_q <= '0; p_q <= '0;
        end else if (conv_en) begin
            h_q <= cfg_h; w_q <= cfg_w; c_q <= cfg_c;
            k_q <= cfg_k; s_q <= cfg_stride; p_q <= cfg_pad;
        end
    end

    // Tap counters advance kx fastest, oy slowest, one step per issued tap.
    always_comb begin
        oy_d = oy_q; ox_d = ox_q; ch_d = ch_q; ky_d = ky_q; kx_d = kx_q;
        if (conv_en) begin
            oy_d = '0; ox_d = '0; ch_d = '0; ky_d = '0; kx_d = '0;
        end else if (issue) begin
            if (!last_kx) begin
                kx_d = kx_q + K_W'(1);
            end else begin
                kx_d = '0;
                if (!last_ky) begin
                    ky_d = ky_q + K_W'(1);
                end else begin
                    ky_d = '0;
                    if (!last_c) begin
                        ch_d = ch_q + DIM_W'(1);
                    end else begin
                        ch_d = '0;
                        if (!last_ox) begin
                            ox_d = ox_q + DIM_W'(1);
                        end else begin
                            ox_d = '0;
                            oy_d = last_oy ? '0 : oy_q + DIM_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Tap counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            oy_q <= '0; ox_q <= '0; ch_q <= '0; ky_q <= '0; kx_q <= '0;
        end else begin
            oy_q <= oy_d; ox_q <= ox_d; ch_q <= ch_d; ky_q <= ky_d; kx_q <= kx_d;
        end
    end

    // Stage 1 tracks the tap whose read data lands this cycle; abort discards it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld_q <= 1'b0; s1_pad_q <= 1'b0; s1_plast_q <= 1'b0; s1_flast_q <= 1'b0;
        end else if (conv_en) begin
            s1_vld_q <= 1'b0; s1_pad_q <= 1'b0; s1_plast_q <= 1'b0; s1_flast_q <= 1'b0;
        end else begin
            s1_vld_q   <= issue;
            s1_pad_q   <= pad_tap;
            s1_plast_q <= patch_last;
            s1_flast_q <= frame_last_tap;
        end
    end

    assign push_beat.data       = s1_pad_q ? '0 : tensor_data;
    assign push_beat.col_last   = s1_plast_q;
    assign push_beat.frame_last = s1_flast_q;

    im2col_reader_fifo2 u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (conv_en),
        .push_i      (s1_vld_q),
        .push_beat_i (push_beat),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

endmodule

// File: doc/im2col_reader.md
Name: im2col_reader

Overview:
- Sits directly downstream of the ping-pong ifmap buffer.
- Drives its tensor read port (tensor_addr / t_addr_vld) and consumes tensor_data one cycle later.
- Emits the convolution input as an im2col column stream to the GEMM array.
- Generates CHW addresses for every kernel tap of every output pixel. Zero-padding taps are inserted without a RAM access. Output is a valid/ready stream with per-patch and per-frame markers.

Parameters:
DATA_WIDTH, `DATA_WIDTH (config.v), element width
ADDR_SIZE, `ADDR_SIZE (config.v), ifmap buffer address width
DIM_W, 8, width of H/W/C configuration fields
K_W, 4, width of kernel size, stride and pad fields

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
enable  in  1  global enable; low = freeze issue of new reads
conv_en  in  1  start pulse; latches cfg_*, restarts the block
cfg_h  in  DIM_W  ifmap height H
cfg_w  in  DIM_W  ifmap width W
cfg_c  in  DIM_W  channel count C
cfg_k  in  K_W  square kernel size K
cfg_stride  in  K_W  stride S
cfg_pad  in  K_W  symmetric zero pad P
tensor_addr  out  ADDR_SIZE  buffer read address
t_addr_vld  out  1  read enable for tensor_addr
tensor_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after t_addr_vld
col_data  out  DATA_WIDTH  im2col element
col_valid  out  1  col_data valid
col_ready  in  1  consumer accepts when col_valid && col_ready
col_last  out  1  last element of current patch (c=C-1, ky=K-1, kx=K-1)
frame_last  out  1  last element of last patch
done  out  1  one-cycle pulse after frame_last beat is accepted

Behaviour:
- Reset (and conv_en): all outputs 0, FIFO emptied, counters zeroed, state IDLE.
- Configuration is latched on conv_en; cfg_* are ignored otherwise.
- Derived values: OH = (H+2P-K)/S+1 and OW = (W+2P-K)/S+1, integer division.
- Loop order, outermost first: oy, ox, c, ky, kx.
  - iy = oy*S+ky-P and ix = ox*S+kx-P, computed signed.
  - Pad tap when iy<0, iy>=H, ix<0 or ix>=W.
  - Otherwise the address is (c*H+iy)*W+ix, truncated to ADDR_SIZE.
- States:
  - IDLE: conv_en -> CHECK.
  - CHECK (1 cycle): if any of H, W, C, K, S is 0, or K>H+2P -> FINISH without output; else -> ISSUE.
  - ISSUE: advances one tap per cycle whenever credit allows. After the last tap is issued -> DRAIN.
  - DRAIN: waits until in-flight and FIFO are empty -> FINISH.
  - FINISH: done=1 for one cycle -> IDLE.
- conv_en in any state aborts immediately:
  - In-flight read is discarded.
  - FIFO is flushed.
  - State goes to CHECK with the new config.
- Issue rule:
  - A tap issues when enable=1 and (fifo_count + inflight - pop) < 2, where pop = col_valid && col_ready this cycle.
  - A real tap asserts t_addr_vld for exactly one cycle. A pad tap keeps t_addr_vld=0 but still occupies the in-flight slot, so ordering is preserved.
- Stage 1:
  - Register {inflight, pad, patch_last, frame_last}.
  - Next cycle, push (pad ? 0 : tensor_data) with its flags into the FIFO.
- Output: 2-entry FIFO; col_valid = FIFO non-empty; head flags drive col_last and frame_last.
- Throughput: 1 element/clk sustained while col_ready=1. No element is dropped or duplicated under any col_ready pattern.
- enable=0 stops new issue only. The in-flight element still lands and the output still drains.
- Latency: first col_valid appears 2 cycles after CHECK exits (issue -> stage1 -> FIFO).

Decomposition:
- DATA_WIDTH, ADDR_SIZE and the state encodings (one-hot, as in the buffer FSM) go in config.v.
- One sub-module, fifo2: 2-entry synchronous FIFO carrying {data, col_last, frame_last}, with flush input, count output and async active-low reset.
- Address and tap counters stay in im2col_reader.

Test Plan:
- Basic: H=W=3, C=1, K=2, S=1, P=0, RAM[i]=i.
  - Expect 16 beats: [0,1,3,4] [1,2,4,5] [3,4,6,7] [4,5,7,8].
  - col_last on beats 4/8/12/16; frame_last and then done after beat 16.
- Padding: H=W=2, C=1, K=3, S=1, P=1, RAM=1,2,3,4.
  - Patch0 = [0,0,0,0,1,2,0,3,4].
  - 4 patches total; t_addr_vld is never high for pad taps.
- Stride and channels:
  - H=W=4, K=2, S=2, C=1 -> patch0 addresses 0,1,4,5, 4 patches.
  - H=W=2, K=2, C=2 -> single patch, addresses 0..7, col_last only on beat 8.
- Backpressure: basic config with col_ready random at 30%.
  - Identical sequence to the basic case.
  - fifo_count + inflight never exceeds 2.
  - Full rate when col_ready is held at 1.
- Abort/illegal:
  - conv_en at beat 5 restarts from patch0 with no stale beat.
  - K=4 on H=W=2, P=0 gives done with zero beats.
  - rstn low mid-stream clears all outputs asynchronously.
